mac_array_ctrl: RTL
===================

// Module: mac_array_ctrl
// PURPOSE
//  Sequencer for the ROWSxCOLS mac_array. Loads 4-bit weights, then streams activation vectors.
//  Drives per-row in_w / ii_w with row skew, so partial sums chain north->south.
//  Asserts out_valid on the cycles when the array's out_s holds a finished result vector.
//  Sits between the weight/activation buffers and the mac_array.
// PARAMETERS
//  ROWS     8   array rows (one in_w nibble and one ii_w word per row)
//  COLS     8   cells per row
//  INST_BW  16  instruction width per row; bits [0]=load weight, [1]=pass x/psum, [3]=simd
//  CNT_BW   8   width of vector counter / cfg_nvec
// PORTS
//  clk        in   1            clock
//  reset      in   1            synchronous, active-low (reset==0 resets on posedge clk)
//  start      in   1            begin job; honoured only in IDLE
//  cfg_simd   in   1            0: 4-bit mode, 1: SIMD 2x2-bit; sampled at accepted start
//  cfg_nvec   in   CNT_BW       activation vectors in job; sampled at start
//  w_data     in   4*ROWS       one weight nibble per row
//  w_valid    in   1            w_data valid
//  w_ready    out  1            weight beat consumed when w_valid&w_ready
//  x_data     in   4*ROWS       one activation nibble per row ({x1,x0} in SIMD)
//  x_valid    in   1            x_data valid
//  x_ready    out  1            activation beat consumed when x_valid&x_ready
//  in_w       out  4*ROWS       to mac_array.in_w
//  ii_w       out  INST_BW*ROWS to mac_array.ii_w
//  busy       out  1            high in any state other than IDLE
//  done       out  1            one-cycle pulse at end of DRAIN
//  out_valid  out  1            mac_array.out_s holds a valid result this cycle
// BEHAVIOUR
//  Reset: state=IDLE; in_w, ii_w, w_ready, x_ready, busy, done and out_valid are all 0.
//    All counters and skew pipes are cleared. Reset mid-job aborts the job silently; no done pulse.
//  FSM: IDLE -(start)-> LOAD -(NLOAD beats taken)-> EXEC -(cfg_nvec beats taken)-> DRAIN -(LAT cycles)-> IDLE.
//    Done pulses in the last DRAIN cycle. cfg_nvec==0 goes LOAD->DRAIN.
//  NLOAD = COLS (cfg_simd=0) or 2*COLS (cfg_simd=1). LAT = ROWS+COLS+2.
//  Row-0 slot per cycle:
//    LOAD: w_ready=1. On a handshake, inst=0x1|simd<<3 with data=w_data.
//      Otherwise bubble: inst=simd<<3, data=0, weights held.
//    EXEC: x_ready=1. On a handshake, inst=0x2|simd<<3 with data=x_data; mark slot valid.
//      Otherwise bubble: inst=0x2|simd<<3, data=0; slot not marked valid.
//    DRAIN: bubble: inst=0x2|simd<<3, data=0.
//    IDLE: inst=0, data=0.
//  Skew:
//    ii_w row r = row-0 instruction delayed r cycles.
//    in_w row r = row-0 data delayed r+1 cycles; data always trails its instruction by exactly 1 cycle.
//    Row 0 is combinational from the slot; use shift-register pipes with no muxing beyond the slot select.
//  out_valid = slot-valid flag delayed LAT cycles. Each accepted x beat yields exactly one out_valid.
//    Bubbles yield none. Order is preserved.
//  Handshakes: the ready signals are functions of state only, never of valid.
//    No beat is taken outside its own state.
//    A start seen while busy is ignored; it is not queued.
//  Simultaneous events:
//    Last LOAD beat: state->EXEC next cycle with no extra bubble.
//    Last EXEC beat: ->DRAIN.
//    A start in the same cycle as done is ignored; the FSM is still in DRAIN.
//  Counters saturate-free: beat counter is clog2(2*COLS+1) bits; drain counter is clog2(LAT+1) bits.
//  Row-0 in_n of the array is tied to zero at top level; it is not driven by this block.
// STRUCTURE
//  Shared package mac_pkg: INST_LOAD=0, INST_PASS=1, INST_SIMD=3 bit indices; state encoding
//    (IDLE/LOAD/EXEC/DRAIN); lat_f(ROWS,COLS) function.
//  Sub-module skew_pipe #(W, DEPTH): reset-clearable shift register.
//    Instantiated per row for ii_w and in_w, and once (DEPTH=LAT) for the valid flag.
// TESTING
//  1 reset=0 for 3 cycles mid-EXEC, then 1 -> all outputs 0, state IDLE, no done, no out_valid for aborted beats.
//  2 cfg_simd=0, cfg_nvec=4, w_valid/x_valid always 1 ->
//    8 w beats, 4 x beats back-to-back;
//    out_valid high exactly at cycles T0+18..T0+21 (T0 = first EXEC cycle);
//    done 1 pulse.
//  3 cfg_simd=1 -> exactly 16 LOAD handshakes; ii_w row0 during LOAD = 16'h0009; during EXEC = 16'h000A.
//  4 x_valid toggling 1,0,1,0 with cfg_nvec=3 -> bubbles carry in_w=0 and inst 0x2;
//    out_valid gaps mirror the input gaps; 3 valids total.
//  5 skew check: ii_w row r equals row0 delayed r cycles; in_w row r equals row-0 data delayed r+1 cycles (all r).
//  6 cfg_nvec=0 -> LOAD then DRAIN, zero x handshakes, zero out_valid, done after LAT cycles.
//    A start during busy is ignored.

Source files
------------

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared instruction bits, FSM encoding and latency helper for the mac_array sequencer
package mac_pkg;

   // Bit positions inside a per-row instruction word
   localparam int INST_LOAD = 0;
   localparam int INST_PASS = 1;
   localparam int INST_SIMD = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_EXEC  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   // Cycles from a row-0 activation slot until its result sits on out_s
   function automatic int lat_f(input int rows, input int cols);
      return rows + cols + 2;
   endfunction

endpackage

// File: rtl/skew_pipe.sv
// rtl/skew_pipe.sv - reset-clearable W-bit shift register of DEPTH stages
module skew_pipe #(
   parameter int W     = 1,
   parameter int DEPTH = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] stage_q [DEPTH];

   // Shift one stage per cycle; a reset empties the whole pipe
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/mac_array_ctrl.sv
// rtl/mac_array_ctrl.sv - weight-load / activation-stream sequencer with row skew for the mac_array
module mac_array_ctrl
   import mac_pkg::*;
#(
   parameter int ROWS    = 8,
   parameter int COLS    = 8,
   parameter int INST_BW = 16,
   parameter int CNT_BW  = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    cfg_simd,
   input  logic [CNT_BW-1:0]       cfg_nvec,
   input  logic [4*ROWS-1:0]       w_data,
   input  logic                    w_valid,
   output logic                    w_ready,
   input  logic [4*ROWS-1:0]       x_data,
   input  logic                    x_valid,
   output logic                    x_ready,
   output logic [4*ROWS-1:0]       in_w,
   output logic [INST_BW*ROWS-1:0] ii_w,
   output logic                    busy,
   output logic                    done,
   output logic                    out_valid
);

   localparam int LAT     = lat_f(ROWS, COLS);
   localparam int BEAT_W  = $clog2(2*COLS + 1);
   localparam int DRAIN_W = $clog2(LAT + 1);

   state_t              state_q, state_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic [CNT_BW-1:0]   vec_q, vec_d;
   logic [CNT_BW-1:0]   nvec_q, nvec_d;
   logic [DRAIN_W-1:0]  drain_q, drain_d;
   logic                simd_q, simd_d;
   logic [BEAT_W-1:0]   nload;

   logic [INST_BW-1:0]  inst0;
   logic [4*ROWS-1:0]   data0;
   logic                slot_vld;

   // SIMD mode packs two 2-bit weights per cell, so twice as many load beats
   assign nload = simd_q ? BEAT_W'(2*COLS) : BEAT_W'(COLS);

   // State and job registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         beat_q  <= '0;
         vec_q   <= '0;
         nvec_q  <= '0;
         drain_q <= '0;
         simd_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         vec_q   <= vec_d;
         nvec_q  <= nvec_d;
         drain_q <= drain_d;
         simd_q  <= simd_d;
      end
   end

   // Next state: ready is a function of state, so valid alone marks a beat taken
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      vec_d   = vec_q;
      nvec_d  = nvec_q;
      drain_d = drain_q;
      simd_d  = simd_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_LOAD;
               simd_d  = cfg_simd;
               nvec_d  = cfg_nvec;
               beat_d  = '0;
               vec_d   = '0;
            end
         end
         ST_LOAD: begin
            if (w_valid) begin
               beat_d = beat_q + 1'b1;
               if (beat_q == nload - 1'b1) begin
                  beat_d  = '0;
                  drain_d = '0;
                  state_d = (nvec_q == '0) ? ST_DRAIN : ST_EXEC;
               end
            end
         end
         ST_EXEC: begin
            if (x_valid) begin
               vec_d = vec_q + 1'b1;
               if (vec_q == nvec_q - 1'b1) begin
                  drain_d = '0;
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            drain_d = drain_q + 1'b1;
            if (drain_q == DRAIN_W'(LAT - 1)) begin
               drain_d = '0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs and the row-0 slot (instruction, data, result-valid marker)
   always_comb begin
      w_ready  = 1'b0;
      x_ready  = 1'b0;
      busy     = (state_q != ST_IDLE);
      done     = 1'b0;
      inst0    = '0;
      data0    = '0;
      slot_vld = 1'b0;
      case (state_q)
         ST_LOAD: begin
            w_ready           = 1'b1;
            inst0[INST_SIMD]  = simd_q;
            if (w_valid) begin
               inst0[INST_LOAD] = 1'b1;
               data0            = w_data;
            end
         end
         ST_EXEC: begin
            x_ready          = 1'b1;
            inst0[INST_PASS] = 1'b1;
            inst0[INST_SIMD] = simd_q;
            if (x_valid) begin
               data0    = x_data;
               slot_vld = 1'b1;
            end
         end
         ST_DRAIN: begin
            inst0[INST_PASS] = 1'b1;
            inst0[INST_SIMD] = simd_q;
            done             = (drain_q == DRAIN_W'(LAT - 1));
         end
         default: ;
      endcase
   end

   // Row r sees the instruction r cycles late and its own data nibble one cycle after that
   for (genvar r = 0; r < ROWS; r++) begin : g_row
      if (r == 0) begin : g_ii0
         assign ii_w[0 +: INST_BW] = inst0;
      end else begin : g_iin
         skew_pipe #(.W(INST_BW), .DEPTH(r)) u_ii (
            .clk   (clk),
            .reset (reset),
            .d_i   (inst0),
            .q_o   (ii_w[r*INST_BW +: INST_BW])
         );
      end
      skew_pipe #(.W(4), .DEPTH(r + 1)) u_in (
         .clk   (clk),
         .reset (reset),
         .d_i   (data0[r*4 +: 4]),
         .q_o   (in_w[r*4 +: 4])
      );
   end

   skew_pipe #(.W(1), .DEPTH(LAT)) u_vld (
      .clk   (clk),
      .reset (reset),
      .d_i   (slot_vld),
      .q_o   (out_valid)
   );

endmodule
